// File: rtl/room_model.sv
// -----------------------------------------------------------------------------
// room_model
//
// Purpose:
//   Thermal plant that closes the loop around the air-conditioning controller.
//   A prescaler produces one update tick every STEP_DIV clocks. On each tick
//   the room warms or cools by one degree while heating or cooling is
//   commanded. With no command, it drifts one degree toward AMBIENT every
//   DRIFT_DIV idle ticks. A synchronous load strobe presets the temperature
//   and restarts all counts.
//
// Configuration macro:
//   ROOM_MODEL_FAULT_EN - when defined, a heat/cool conflict at an update edge
//                         sets a sticky fault flag that only load or reset
//                         clears. When undefined, fault is tied low.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   heating      in   heat command (sampled at update edges)
//   cooling      in   cool command (sampled at update edges)
//   load         in   synchronous preset strobe, has priority over ticks
//   load_temp    in   5-bit preset value, clamped to [TMIN, TMAX]
//   temperature  out  registered room temperature
//   tick         out  high during the cycle that ends in an update edge
//   at_min       out  temperature == TMIN
//   at_max       out  temperature == TMAX
//   fault        out  sticky command-conflict flag
// -----------------------------------------------------------------------------
module room_model #(
  parameter int unsigned INIT_TEMP = 20,
  parameter int unsigned AMBIENT   = 25,
  parameter int unsigned STEP_DIV  = 8,
  parameter int unsigned DRIFT_DIV = 4,
  parameter int unsigned TMIN      = 0,
  parameter int unsigned TMAX      = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       heating,
  input  logic       cooling,
  input  logic       load,
  input  logic [4:0] load_temp,
  output logic [4:0] temperature,
  output logic       tick,
  output logic       at_min,
  output logic       at_max,
  output logic       fault
);

  // Counter widths stay at least one bit so DRIFT_DIV == 1 still elaborates.
  localparam int unsigned PW = (STEP_DIV  > 1) ? $clog2(STEP_DIV)  : 1;
  localparam int unsigned DW = (DRIFT_DIV > 1) ? $clog2(DRIFT_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DRIFT_LAST = DW'(DRIFT_DIV - 1);

  localparam logic [5:0] TMIN6 = 6'(TMIN);
  localparam logic [5:0] TMAX6 = 6'(TMAX);
  localparam logic [5:0] AMB6  = 6'(AMBIENT);
  localparam logic [4:0] TMIN5 = 5'(TMIN);
  localparam logic [4:0] TMAX5 = 5'(TMAX);
  localparam logic [4:0] INIT5 = 5'(INIT_TEMP);

  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] drift_q, drift_d;
  logic [4:0]    temp_q,  temp_d;
  logic [5:0]    temp6;

  // Saturate a 6-bit intermediate into the legal range before write-back,
  // so the 5-bit register can never wrap.
  function automatic logic [4:0] clamp6(input logic [5:0] v);
    if (v < TMIN6) begin
      return TMIN5;
    end else if (v > TMAX6) begin
      return TMAX5;
    end else begin
      return v[4:0];
    end
  endfunction

  assign temp6 = {1'b0, temp_q};
  assign tick  = (presc_q == PRE_LAST);

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    presc_d = tick ? '0 : presc_q + PW'(1);
    drift_d = drift_q;
    temp_d  = temp_q;

    if (load) begin
      temp_d  = clamp6({1'b0, load_temp});
      presc_d = '0;
      drift_d = '0;
    end else if (tick) begin
      unique case ({heating, cooling})
        2'b10: begin
          temp_d  = clamp6(temp6 + 6'd1);
          drift_d = '0;
        end
        2'b01: begin
          // Guard zero so the decrement cannot wrap to 63 and clamp to TMAX.
          temp_d  = clamp6((temp6 == 6'd0) ? 6'd0 : temp6 - 6'd1);
          drift_d = '0;
        end
        2'b11: begin
          // Conflict: hold temperature but restart the idle interval.
          drift_d = '0;
        end
        default: begin
          if (drift_q == DRIFT_LAST) begin
            drift_d = '0;
            if (temp6 < AMB6) begin
              temp_d = clamp6(temp6 + 6'd1);
            end else if (temp6 > AMB6) begin
              temp_d = clamp6(temp6 - 6'd1);
            end
          end else begin
            drift_d = drift_q + DW'(1);
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its next-state value from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      drift_q <= '0;
      temp_q  <= INIT5;
    end else begin
      presc_q <= presc_d;
      drift_q <= drift_d;
      temp_q  <= temp_d;
    end
  end

  assign temperature = temp_q;
  assign at_min      = (temp_q == TMIN5);
  assign at_max      = (temp_q == TMAX5);

`ifdef ROOM_MODEL_FAULT_EN
  logic fault_q;
  logic conflict;

  // A conflict only counts at an update edge that load does not override.
  assign conflict = tick & heating & cooling & ~load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (load) begin
      fault_q <= 1'b0;
    end else if (conflict) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule
